move_scanner: RTL and testbench

Scans every playable square of the padded 10x10 board for the current player and reports whether any legal move exists, how many there are, and the first one found. It sits beside the new-move controller and shares the validator with it, driving one direction check at a time through the validator's load/start/done handshake. The main controller uses the result to detect a pass or game end and to drive move hints. The scanner never writes the board.

---
 rtl/othello_pkg.sv | 48 ++++
 rtl/scan_pos_counter.sv | 52 +++++
 rtl/move_scanner.sv | 161 ++++++++++++++++
 tb/tb_move_scanner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared Othello definitions: padded-board geometry, direction step constants,
// the direction-to-(step, sign) table used by the move validator clients, and
// the move scanner state encoding.
package othello_pkg;

    // Padded 10x10 board: row pitch and the first/last playable squares.
    localparam int BOARD_W   = 10;
    localparam int FIRST_POS = 11;
    localparam int LAST_POS  = 88;

    // Direction step magnitudes on the padded board.
    localparam logic [4:0] STEP_ROW    = 5'd10;
    localparam logic [4:0] STEP_COL    = 5'd1;
    localparam logic [4:0] STEP_DIAG_A = 5'd9;
    localparam logic [4:0] STEP_DIAG_B = 5'd11;

    // Step magnitude plus direction of travel (1 = subtract, 0 = add).
    typedef struct packed {
        logic [4:0] step;
        logic       sign;
    } dir_step_t;

    // Direction order: U, D, L, R, then the diagonals UL, UR, DL, DR.
    function automatic dir_step_t dir_to_step(input logic [2:0] dir);
        dir_step_t r;
        case (dir)
            3'd0:    r = '{step: STEP_ROW,    sign: 1'b1};
            3'd1:    r = '{step: STEP_ROW,    sign: 1'b0};
            3'd2:    r = '{step: STEP_COL,    sign: 1'b1};
            3'd3:    r = '{step: STEP_COL,    sign: 1'b0};
            3'd4:    r = '{step: STEP_DIAG_B, sign: 1'b1};
            3'd5:    r = '{step: STEP_DIAG_A, sign: 1'b1};
            3'd6:    r = '{step: STEP_DIAG_A, sign: 1'b0};
            default: r = '{step: STEP_DIAG_B, sign: 1'b0};
        endcase
        return r;
    endfunction

    // Move scanner FSM encoding.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_TEST    = 3'd2;
    localparam logic [2:0] S_VALI_S  = 3'd3;
    localparam logic [2:0] S_VALI    = 3'd4;
    localparam logic [2:0] S_NEXT_SQ = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

endpackage

// File: rtl/scan_pos_counter.sv
// Walks the playable squares of the padded board in row-major order.
// A zero-based column counter decides when to jump over the two border
// columns (col 9 of this row, col 0 of the next) to the next row's column 1.
module scan_pos_counter #(
    parameter int BOARD_W   = 10,
    parameter int FIRST_POS = 11,
    parameter int LAST_POS  = 88
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [6:0] pos,
    output logic       last
);

    logic [6:0] pos_q, pos_d;
    logic [2:0] col_q, col_d;

    // Next square: restart at FIRST_POS, step right, or wrap to the next row.
    always_comb begin
        pos_d = pos_q;
        col_d = col_q;
        if (clear) begin
            pos_d = 7'(FIRST_POS);
            col_d = '0;
        end else if (advance) begin
            if (col_q == 3'd7) begin
                pos_d = pos_q + 7'(BOARD_W - 7);
                col_d = '0;
            end else begin
                pos_d = pos_q + 7'd1;
                col_d = col_q + 3'd1;
            end
        end
    end

    // Position and column registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pos_q <= '0;
            col_q <= '0;
        end else begin
            pos_q <= pos_d;
            col_q <= col_d;
        end
    end

    assign pos  = pos_q;
    assign last = (pos_q == 7'(LAST_POS));

endmodule

// File: rtl/move_scanner.sv
// Legal-move scanner: visits every playable square, and for each empty one
// asks the shared validator about each direction in turn until one succeeds.
// Reports the number of legal squares and the lowest legal square.
// Build option: MOVE_SCANNER_DIAG_EN adds the four diagonal directions.
module move_scanner #(
    parameter int BOARD_W   = othello_pkg::BOARD_W,
    parameter int FIRST_POS = othello_pkg::FIRST_POS,
    parameter int LAST_POS  = othello_pkg::LAST_POS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [6:0] sq_addr_o,
    input  logic       sq_empty_in,
    output logic [6:0] pos_o,
    output logic [4:0] step_o,
    output logic       step_sign_o,
    output logic       ld_vali_o,
    output logic       start_vali_o,
    input  logic       s_done_vali,
    input  logic       dir_status_in,
    output logic       busy_o,
    output logic       scan_done_o,
    output logic       has_move_o,
    output logic [6:0] move_count_o,
    output logic [6:0] first_move_o
);
    import othello_pkg::*;

`ifdef MOVE_SCANNER_DIAG_EN
    localparam int DIR_W = 3;
`else
    localparam int DIR_W = 2;
`endif
    localparam logic [DIR_W-1:0] DIR_LAST = '1;

    logic [2:0]       state_q, state_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic [6:0]       count_q, count_d;
    logic [6:0]       first_q, first_d;
    logic [6:0]       pos;
    logic             last;
    logic             pos_clear;
    logic             pos_advance;
    dir_step_t        cur_step;

    scan_pos_counter #(
        .BOARD_W  (BOARD_W),
        .FIRST_POS(FIRST_POS),
        .LAST_POS (LAST_POS)
    ) u_pos (
        .clock  (clock),
        .reset  (reset),
        .clear  (pos_clear),
        .advance(pos_advance),
        .pos    (pos),
        .last   (last)
    );

    assign cur_step = dir_to_step(3'(dir_q));

    // FSM sequencing, direction stepping and result accumulation.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        count_d     = count_q;
        first_d     = first_q;
        pos_clear   = 1'b0;
        pos_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    count_d   = '0;
                    first_d   = '0;
                    pos_clear = 1'b1;
                    state_d   = S_READ;
                end
            end
            S_READ:   state_d = S_TEST;
            S_TEST: begin
                if (!sq_empty_in) begin
                    state_d = S_NEXT_SQ;
                end else begin
                    dir_d   = '0;
                    state_d = S_VALI_S;
                end
            end
            S_VALI_S: state_d = S_VALI;
            S_VALI: begin
                if (s_done_vali) begin
                    if (dir_status_in) begin
                        // One legal direction is enough; skip the rest so
                        // the square is counted once.
                        count_d = count_q + 7'd1;
                        if (count_q == 7'd0) begin
                            first_d = pos;
                        end
                        state_d = S_NEXT_SQ;
                    end else if (dir_q == DIR_LAST) begin
                        state_d = S_NEXT_SQ;
                    end else begin
                        dir_d   = dir_q + 1'b1;
                        state_d = S_VALI_S;
                    end
                end
            end
            S_NEXT_SQ: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    pos_advance = 1'b1;
                    state_d     = S_READ;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, direction and result registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dir_q   <= '0;
            count_q <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            first_q <= first_d;
        end
    end

    // State-decoded outputs; validator lines are quiet except in S_VALI_S.
    always_comb begin
        sq_addr_o    = '0;
        pos_o        = '0;
        step_o       = '0;
        step_sign_o  = 1'b0;
        ld_vali_o    = 1'b0;
        start_vali_o = 1'b0;
        if (state_q == S_READ) begin
            sq_addr_o = pos;
        end
        if (state_q == S_VALI_S) begin
            pos_o        = pos;
            step_o       = cur_step.step;
            step_sign_o  = cur_step.sign;
            ld_vali_o    = 1'b1;
            start_vali_o = 1'b1;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign scan_done_o  = (state_q == S_DONE);
    assign has_move_o   = (count_q != 7'd0);
    assign move_count_o = count_q;
    assign first_move_o = first_q;

endmodule

// File: tb/tb_move_scanner.sv
// Bench for move_scanner: board RAM and validator behavioural models,
// directed scenarios plus randomized boards checked against a square-by-square
// reference of the scanning rules.
module tb_move_scanner;

`ifdef MOVE_SCANNER_DIAG_EN
    localparam int ND = 8;
`else
    localparam int ND = 4;
`endif
    localparam int BUDGET = 20000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       sq_empty_in = 1'b0;
    logic       s_done_vali = 1'b0;
    logic       dir_status_in = 1'b0;
    logic [6:0] sq_addr_o, pos_o, move_count_o, first_move_o;
    logic [4:0] step_o;
    logic       step_sign_o, ld_vali_o, start_vali_o, busy_o, scan_done_o, has_move_o;

    move_scanner dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sq_addr_o    (sq_addr_o),
        .sq_empty_in  (sq_empty_in),
        .pos_o        (pos_o),
        .step_o       (step_o),
        .step_sign_o  (step_sign_o),
        .ld_vali_o    (ld_vali_o),
        .start_vali_o (start_vali_o),
        .s_done_vali  (s_done_vali),
        .dir_status_in(dir_status_in),
        .busy_o       (busy_o),
        .scan_done_o  (scan_done_o),
        .has_move_o   (has_move_o),
        .move_count_o (move_count_o),
        .first_move_o (first_move_o)
    );

    initial forever #5 clock = ~clock;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Board contents and per-square legal-direction masks (bit d = direction d
    // in the order U, D, L, R, UL, UR, DL, DR).
    bit       empty [0:127];
    bit [7:0] mask  [0:127];
    int       lat = 1;

    int step_tab [8] = '{10, 10, 1, 1, 11, 9, 9, 11};
    int sign_tab [8] = '{1, 0, 1, 0, 1, 1, 0, 0};

    // Validator-side observation counters.
    int strobes, order_err, viol, dbl;
    int cur_sq = -1;
    int cur_idx = 0;
    int cnt = 0;
    bit res = 0;
    bit prev_start = 0;

    function automatic int decode(input int step, input int sign);
        int d = -1;
        for (int i = 0; i < 8; i++)
            if (step_tab[i] == step && sign_tab[i] == sign) d = i;
        return d;
    endfunction

    // Board RAM (data follows the address by one cycle) and validator model.
    initial begin
        int d;
        forever begin
            @(negedge clock);
            if (sq_addr_o != 7'd0) sq_empty_in = empty[sq_addr_o];
            s_done_vali   = 1'b0;
            dir_status_in = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    s_done_vali   = 1'b1;
                    dir_status_in = res;
                end
            end
            if (!start_vali_o && (ld_vali_o || pos_o != 0 || step_o != 0 || step_sign_o))
                viol++;
            if (start_vali_o) begin
                if (!ld_vali_o) viol++;
                if (prev_start || cnt > 0) dbl++;
                strobes++;
                if (int'(pos_o) != cur_sq) begin
                    cur_sq  = int'(pos_o);
                    cur_idx = 0;
                end
                d = decode(int'(step_o), int'(step_sign_o));
                if (d != cur_idx) order_err++;
                cur_idx++;
                res = (d >= 0) && mask[pos_o][d];
                cnt = lat;
            end
            prev_start = start_vali_o;
        end
    end

    // Reference: count empty squares with any legal direction among the
    // enabled ones, lowest such square, and validator starts needed.
    task automatic ref_model(output int ecount, output int efirst, output int estrobes);
        ecount = 0; efirst = 0; estrobes = 0;
        for (int r = 1; r <= 8; r++) begin
            for (int c = 1; c <= 8; c++) begin
                int sq;
                bit ok;
                sq = r * 10 + c;
                ok = 0;
                if (empty[sq]) begin
                    for (int d = 0; d < ND && !ok; d++) begin
                        estrobes++;
                        if (mask[sq][d]) ok = 1;
                    end
                    if (ok) begin
                        if (ecount == 0) efirst = sq;
                        ecount++;
                    end
                end
            end
        end
    endtask

    task automatic clear_board(input bit e);
        for (int i = 0; i < 128; i++) begin
            empty[i] = 1'b0;
            mask[i]  = 8'h00;
        end
        for (int r = 1; r <= 8; r++)
            for (int c = 1; c <= 8; c++) empty[r * 10 + c] = e;
    endtask

    // Runs one scan from enable to completion (called at posedge+1).
    task automatic do_scan(input string tag, input bit extra_en, output int done_at);
        int ecount, efirst, estrobes, ndone;
        ref_model(ecount, efirst, estrobes);
        strobes = 0; order_err = 0; viol = 0; dbl = 0; cur_sq = -1;
        ndone = 0; done_at = -1;
        enable = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        chk({tag, " first_addr"}, int'(sq_addr_o), 11);
        for (int n = 1; n <= BUDGET; n++) begin
            if (extra_en && (n == 30 || n == 100)) enable = 1'b1;
            @(posedge clock); #1;
            enable = 1'b0;
            if (scan_done_o) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (done_at >= 0 && n >= done_at + 20) break;
        end
        chk({tag, " done_seen"}, int'(done_at >= 0), 1);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " busy_after"}, int'(busy_o), 0);
        chk({tag, " count"}, int'(move_count_o), ecount);
        chk({tag, " first"}, int'(first_move_o), efirst);
        chk({tag, " has_move"}, int'(has_move_o), int'(ecount != 0));
        chk({tag, " strobes"}, strobes, estrobes);
        chk({tag, " dir_order"}, order_err, 0);
        chk({tag, " quiet_vali"}, viol, 0);
        chk({tag, " single_strobe"}, dbl, 0);
    endtask

    task automatic opening_board();
        clear_board(1'b1);
        empty[44] = 0; empty[45] = 0; empty[54] = 0; empty[55] = 0;
        mask[34] = 8'h05; mask[43] = 8'h05; mask[56] = 8'h05; mask[65] = 8'h05;
    endtask

    initial begin
        int done_at;
        clear_board(1'b0);
        repeat (3) @(posedge clock);
        #1;
        chk("rst busy", int'(busy_o), 0);
        chk("rst done", int'(scan_done_o), 0);
        chk("rst count", int'(move_count_o), 0);
        chk("rst first", int'(first_move_o), 0);
        chk("rst has", int'(has_move_o), 0);
        chk("rst addr", int'(sq_addr_o), 0);
        chk("rst start", int'(start_vali_o), 0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Fully occupied board: pure walk timing, no validator activity.
        clear_board(1'b0);
        do_scan("full", 1'b0, done_at);
        chk("full latency", done_at, 192);

        // Standard opening.
        opening_board();
        lat = 1;
        do_scan("opening", 1'b0, done_at);
        chk("opening count", int'(move_count_o), 4);
        chk("opening first", int'(first_move_o), 34);

        // Slow validator.
        lat = 5;
        do_scan("stall", 1'b0, done_at);
        chk("stall count", int'(move_count_o), 4);

        // Enable pulses while busy are ignored.
        lat = 2;
        do_scan("busy_en", 1'b1, done_at);

        // Reset in the middle of a scan.
        enable = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("midrst busy", int'(busy_o), 0);
        chk("midrst count", int'(move_count_o), 0);
        chk("midrst first", int'(first_move_o), 0);
        chk("midrst has", int'(has_move_o), 0);
        chk("midrst start", int'(start_vali_o), 0);
        chk("midrst addr", int'(sq_addr_o), 0);
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("midrst stale busy", int'(busy_o), 0);
        chk("midrst stale count", int'(move_count_o), 0);
        do_scan("restart", 1'b0, done_at);

        // Square 45 legal only along DR.
        clear_board(1'b0);
        empty[45] = 1'b1;
        mask[45]  = 8'h80;
        lat = 1;
        do_scan("dr45", 1'b0, done_at);
`ifdef MOVE_SCANNER_DIAG_EN
        chk("dr45 spec count", int'(move_count_o), 1);
        chk("dr45 spec first", int'(first_move_o), 45);
`else
        chk("dr45 spec count", int'(move_count_o), 0);
`endif

        // Randomized boards and validator latencies.
        for (int t = 0; t < 4; t++) begin
            clear_board(1'b0);
            for (int r = 1; r <= 8; r++) begin
                for (int c = 1; c <= 8; c++) begin
                    empty[r * 10 + c] = ($urandom_range(0, 1) == 1);
                    mask[r * 10 + c]  = 8'($urandom & $urandom & $urandom);
                end
            end
            lat = int'($urandom_range(1, 4));
            do_scan($sformatf("rand%0d", t), 1'b0, done_at);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
